// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - multi-clip sample-ROM address sequencer with priority, loop, pause and stop
module sound_sequencer #(
    parameter int N         = 16,
    parameter int NCH       = 4,
    parameter int RETRIGGER = 0,
    localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               Sound_clk,
    input  logic               Reset,
    input  logic [NCH-1:0]     Play,
    input  logic               Loop,
    input  logic               Stop,
    input  logic               Pause,
    input  logic [NCH*N-1:0]   Base,
    input  logic [NCH*N-1:0]   Length,
    output logic               Playing,
    output logic               Paused,
    output logic               Done,
    output logic               Done_pulse,
    output logic [CW-1:0]      Clip,
    output logic [N-1:0]       Addr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PLAY   = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state;
    logic [N-1:0]  offset;
    logic [N-1:0]  addr_q;
    logic [CW-1:0] clip_q;
    logic          loop_q;
    logic          done_pulse_q;

    logic          any_req;
    logic [CW-1:0] win_idx;
    logic [N-1:0]  win_base;
    logic [N-1:0]  win_len;
    logic [N-1:0]  cur_base;
    logic [N-1:0]  cur_len;
    logic          start;

    // Scan from the top so the lowest set request index ends up winning.
    always_comb begin
        any_req = |Play;
        win_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (Play[k]) win_idx = CW'(k);
        end
    end

    assign win_base = Base[int'(win_idx) * N +: N];
    assign win_len  = Length[int'(win_idx) * N +: N];
    assign cur_base = Base[int'(clip_q) * N +: N];
    assign cur_len  = Length[int'(clip_q) * N +: N];

    always_comb begin
        start = 1'b0;
        case (state)
            S_IDLE, S_DONE:   start = any_req;
            S_PLAY, S_PAUSED: start = any_req &&
                                      ((win_idx < clip_q) ||
                                       ((RETRIGGER != 0) && (win_idx == clip_q)));
            default:          start = 1'b0;
        endcase
    end

    always_ff @(posedge Sound_clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            offset       <= '0;
            addr_q       <= '0;
            clip_q       <= '0;
            loop_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            if (Stop) begin
                state <= S_IDLE;
            end else if (start) begin
                clip_q <= win_idx;
                offset <= '0;
                loop_q <= Loop;
                // A zero-length clip has nothing to present, so it completes immediately.
                if (win_len == '0) begin
                    state        <= S_DONE;
                    done_pulse_q <= 1'b1;
                end else begin
                    state  <= S_PLAY;
                    addr_q <= win_base;
                end
            end else begin
                case (state)
                    S_PLAY: begin
                        if (Pause) begin
                            state <= S_PAUSED;
                        end else if (offset == cur_len - N'(1)) begin
                            if (loop_q) begin
                                offset <= '0;
                                addr_q <= cur_base;
                            end else begin
                                state        <= S_DONE;
                                done_pulse_q <= 1'b1;
                            end
                        end else begin
                            offset <= offset + N'(1);
                            addr_q <= cur_base + offset + N'(1);
                        end
                    end
                    S_PAUSED: begin
                        if (!Pause) state <= S_PLAY;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Playing    = (state == S_PLAY) || (state == S_PAUSED);
    assign Paused     = (state == S_PAUSED);
    assign Done       = (state == S_DONE);
    assign Done_pulse = done_pulse_q;
    assign Clip       = clip_q;
    assign Addr       = addr_q;

endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameter N, default 16, width of the sample ROM address.
REQ-002 Parameter NCH, default 4, number of sound clips stored in the shared ROM (NCH >= 1).
REQ-003 Parameter RETRIGGER, default 0; 1 allows a clip to restart itself.
REQ-004 Sound_clk  input  1  sample clock (nominally 48 kHz), the only clock; all logic is on its rising edge.
REQ-005 Reset  input  1  reset, synchronous, active-high.
REQ-006 Play  input  NCH  per-clip play request, level-sampled each cycle; bit 0 has the highest priority.
REQ-007 Loop  input  1  mode for the clip being started: 1 = loop, 0 = one-shot; latched at start.
REQ-008 Stop  input  1  abort the current clip.
REQ-009 Pause  input  1  freeze playback while high.
REQ-010 Base  input  NCH*N  clip k start address, in bits [k*N +: N].
REQ-011 Length  input  NCH*N  clip k sample count, in bits [k*N +: N].
REQ-012 Playing  output  1  high in states PLAY and PAUSED.
REQ-013 Paused  output  1  high in state PAUSED.
REQ-014 Done  output  1  level; high after a one-shot clip completes, until the next start or Stop.
REQ-015 Done_pulse  output  1  one-cycle pulse in the first cycle Done is high.
REQ-016 Clip  output  clog2(NCH) bits (minimum 1)  index of the latched clip.
REQ-017 Addr  output  N  ROM address.

Function
REQ-018 The block shall use states IDLE, PLAY, PAUSED and DONE, with an internal N-bit offset counter.
REQ-019 The winning request shall be the lowest set index of Play, selected combinationally.
REQ-020 A start of clip k shall, on the next edge, set Clip=k, offset=0, Addr=Base[k], latch Loop, enter PLAY, and clear Done.
REQ-021 A start shall occur from IDLE or DONE whenever any Play bit is set.
REQ-022 A start shall occur from PLAY or PAUSED only if the winner index is less than Clip (preemption), or equals Clip when RETRIGGER=1; other requests are ignored.
REQ-023 In PLAY with Pause=0, each cycle shall increment offset, with Addr = Base[Clip] + offset modulo 2^N (wrap-around permitted).
REQ-024 Each of the addresses Base to Base+Length-1 shall be presented for exactly one PLAY cycle; no extra address shall appear past the end.
REQ-025 The end of a clip occurs when offset = Length-1 in PLAY with Pause=0.
REQ-026 At the end of a looped clip, the next edge shall set offset=0 and Addr=Base, and the block shall stay in PLAY.
REQ-027 At the end of a one-shot clip, the next edge shall enter DONE with Done=1 and Done_pulse=1, and Addr shall hold its last value.
REQ-028 Pause=1 in PLAY shall enter PAUSED with offset and Addr held; Pause=0 in PAUSED shall return to PLAY, with the increment resuming on the following edge.
REQ-029 Stop=1 shall have priority over Play and Pause: next state IDLE, Playing=0, Done=0, Addr and Clip held.
REQ-030 A start while Pause=1 shall enter PLAY; the pause shall then take effect on the following edge.
REQ-031 A start of a clip whose Length is 0 shall go directly to DONE with Done_pulse=1, and no address shall be played.
REQ-032 Base and Length shall be sampled live; they must be held stable while their clip plays.
REQ-033 Simultaneous end of clip and a higher-priority request: the start shall win, and no Done shall be asserted.

Reset
REQ-034 While Reset=1, the block shall enter IDLE with Addr=0, Clip=0, offset=0, Playing=0, Paused=0, Done=0, Done_pulse=0 and latched Loop=0.
REQ-035 Reset asserted mid-clip shall abort playback on that edge, with no Done or Done_pulse asserted.

Verification
REQ-036 One-shot: Base[1]=100, Length[1]=3, Play=0010 for 1 cycle -> Addr 100,101,102 in consecutive PLAY cycles, then DONE with Done_pulse for 1 cycle and Addr held at 102.
REQ-037 Loop: Base[0]=0xFFFE, Length[0]=3, Loop=1 -> Addr FFFE, FFFF, 0000, FFFE, ...; Done stays 0; Stop -> IDLE next edge.
REQ-038 Priority: clip 2 playing, Play=0101 -> Clip=0, Addr=Base[0] next edge; then Play=1000 -> ignored.
REQ-039 Pause: Pause high for 5 cycles at offset 4 of Length 10 -> Addr frozen, Paused=1; after release, 10 distinct addresses total, then Done.
REQ-040 Edges: Length=0 -> immediate Done_pulse; Reset mid-play -> all outputs at reset values next edge; RETRIGGER=1 with same clip -> restart at Base.
